// File: rtl/rc_seq_pkg.sv
// -----------------------------------------------------------------------------
// rc_seq_pkg
// Shared definitions for the RC step sequencer slice:
//   - default parameter values (level/sample width, table depth, hold width)
//   - sequencer state encoding
//   - segment-table entry layout {level, hold} at the default widths
// -----------------------------------------------------------------------------
package rc_seq_pkg;

  localparam int DEF_WIDTH  = 18;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_HOLD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // One segment: drive `level` into the model for `hold` cycles (0 acts as 1).
  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] level;
    logic [DEF_HOLD_W-1:0]       hold;
  } seg_entry_t;

endpackage

// File: rtl/rc_step_sequencer_if.sv
// -----------------------------------------------------------------------------
// rc_step_sequencer_if
// Bundles every non-clock signal of the RC step sequencer.
//   master : controller side (table config, run control, model output)
//   slave  : sequencer side
// Signals:
//   cfg_we/cfg_addr/cfg_level/cfg_hold : segment-table write port
//   num_seg, loop_en, start, stop      : run control
//   v_out_fx                           : model output (fixed point)
//   v_in_fx, model_en                  : model drive
//   busy, seg_idx                      : run status
//   sample_valid, sample_data, done    : per-segment sample / completion
// -----------------------------------------------------------------------------
interface rc_step_sequencer_if #(
  parameter int WIDTH  = 18,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                    cfg_we;
  logic [AW-1:0]           cfg_addr;
  logic signed [WIDTH-1:0] cfg_level;
  logic [HOLD_W-1:0]       cfg_hold;
  logic [AW:0]             num_seg;
  logic                    loop_en;
  logic                    start;
  logic                    stop;
  logic signed [WIDTH-1:0] v_out_fx;
  logic signed [WIDTH-1:0] v_in_fx;
  logic                    model_en;
  logic                    busy;
  logic [AW-1:0]           seg_idx;
  logic                    sample_valid;
  logic signed [WIDTH-1:0] sample_data;
  logic                    done;

  modport master (
    output cfg_we, cfg_addr, cfg_level, cfg_hold,
    output num_seg, loop_en, start, stop, v_out_fx,
    input  v_in_fx, model_en, busy, seg_idx, sample_valid, sample_data, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_level, cfg_hold,
    input  num_seg, loop_en, start, stop, v_out_fx,
    output v_in_fx, model_en, busy, seg_idx, sample_valid, sample_data, done
  );

endinterface

// File: rtl/rc_seq_table.sv
// -----------------------------------------------------------------------------
// rc_seq_table
// DEPTH-entry segment register file, one synchronous write port and one
// combinational read port. Reset clears every entry to level 0, hold 0.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   we_i, waddr_i      : write strobe / address
//   wlevel_i, whold_i  : data written
//   raddr_i            : read address
//   rlevel_o, rhold_o  : entry at raddr_i
// -----------------------------------------------------------------------------
module rc_seq_table #(
  parameter int WIDTH  = 18,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_i,
  input  logic [$clog2(DEPTH)-1:0]     waddr_i,
  input  logic signed [WIDTH-1:0]      wlevel_i,
  input  logic [HOLD_W-1:0]            whold_i,
  input  logic [$clog2(DEPTH)-1:0]     raddr_i,
  output logic signed [WIDTH-1:0]      rlevel_o,
  output logic [HOLD_W-1:0]            rhold_o
);

  logic signed [WIDTH-1:0] level_q [DEPTH];
  logic [HOLD_W-1:0]       hold_q  [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        level_q[i] <= '0;
        hold_q[i]  <= '0;
      end
    end else if (we_i) begin
      level_q[waddr_i] <= wlevel_i;
      hold_q[waddr_i]  <= whold_i;
    end
  end

  assign rlevel_o = level_q[raddr_i];
  assign rhold_o  = hold_q[raddr_i];

endmodule

// File: rtl/rc_step_sequencer.sv
// -----------------------------------------------------------------------------
// rc_step_sequencer
// Plays a table of {level, hold} segments into an RC-circuit emulator: each
// segment drives v_in_fx for `hold` cycles with the emulator enabled, and the
// emulator output is sampled on the last cycle of every segment. Runs once
// (ending with a one-cycle done pulse) or loops until stopped.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : rc_step_sequencer_if.slave (config, control, model I/O, status)
// -----------------------------------------------------------------------------
module rc_step_sequencer
  import rc_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  rc_step_sequencer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  seq_state_t              state_q;
  logic [AW-1:0]           seg_q;
  logic [HOLD_W-1:0]       cnt_q;
  logic signed [WIDTH-1:0] v_in_q;
  logic signed [WIDTH-1:0] sample_q;
  logic                    busy_q;
  logic                    model_en_q;
  logic                    sample_valid_q;
  logic                    done_q;
  logic [NW-1:0]           nseg_q;
  logic                    loop_q;

  logic                    last_seg;
  logic [AW-1:0]           rd_addr_d;
  logic signed [WIDTH-1:0] rd_level;
  logic [HOLD_W-1:0]       rd_hold;
  logic [HOLD_W-1:0]       rd_hold_eff;
  logic                    start_ok;
  logic                    tbl_we;

  // The single read port always points at the segment that would be loaded
  // next: entry 0 when idle or on wrap, otherwise seg_q+1. That lets start,
  // advance and loop-wrap share one combinational read.
  always_comb begin
    last_seg  = ({1'b0, seg_q} == (nseg_q - NW'(1)));
    rd_addr_d = '0;
    if (state_q == ST_RUN && !last_seg) begin
      rd_addr_d = seg_q + AW'(1);
    end
  end

  assign rd_hold_eff = (rd_hold == '0) ? HOLD_W'(1) : rd_hold;

  assign start_ok = bus.start && !bus.stop &&
                    (bus.num_seg != '0) && (bus.num_seg <= NW'(DEPTH));

  assign tbl_we = bus.cfg_we && (state_q == ST_IDLE);

  rc_seq_table #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .we_i     (tbl_we),
    .waddr_i  (bus.cfg_addr),
    .wlevel_i (bus.cfg_level),
    .whold_i  (bus.cfg_hold),
    .raddr_i  (rd_addr_d),
    .rlevel_o (rd_level),
    .rhold_o  (rd_hold)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      seg_q          <= '0;
      cnt_q          <= '0;
      v_in_q         <= '0;
      sample_q       <= '0;
      busy_q         <= 1'b0;
      model_en_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      nseg_q         <= '0;
      loop_q         <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q    <= ST_RUN;
            seg_q      <= '0;
            v_in_q     <= rd_level;
            cnt_q      <= rd_hold_eff;
            nseg_q     <= bus.num_seg;
            loop_q     <= bus.loop_en;
            busy_q     <= 1'b1;
            model_en_q <= 1'b1;
          end
        end

        ST_RUN: begin
          if (bus.stop) begin
            state_q    <= ST_IDLE;
            seg_q      <= '0;
            cnt_q      <= '0;
            v_in_q     <= '0;
            busy_q     <= 1'b0;
            model_en_q <= 1'b0;
          end else if (cnt_q <= HOLD_W'(1)) begin
            sample_valid_q <= 1'b1;
            sample_q       <= bus.v_out_fx;
            if (!last_seg) begin
              seg_q  <= seg_q + AW'(1);
              v_in_q <= rd_level;
              cnt_q  <= rd_hold_eff;
            end else if (loop_q) begin
              seg_q  <= '0;
              v_in_q <= rd_level;
              cnt_q  <= rd_hold_eff;
            end else begin
              state_q    <= ST_DONE;
              cnt_q      <= '0;
              busy_q     <= 1'b0;
              model_en_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - HOLD_W'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          if (bus.stop) begin
            seg_q  <= '0;
            v_in_q <= '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.v_in_fx      = v_in_q;
  assign bus.model_en     = model_en_q;
  assign bus.busy         = busy_q;
  assign bus.seg_idx      = seg_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_data  = sample_q;
  assign bus.done         = done_q;

endmodule

// File: doc/rc_step_sequencer.md
RC_STEP_SEQUENCER -- requirements
Module: rc_step_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 18: signed fixed-point width of level and sample words, same scaling as the model's v_in/v_out reals.
REQ-002 SHALL have parameter DEPTH, default 8: number of segment-table entries (power of 2).
REQ-003 SHALL have parameter HOLD_W, default 16: width of per-segment hold count.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- cfg_we  in  1  table write strobe.
- cfg_addr  in  $clog2(DEPTH)  table write address.
- cfg_level  in  WIDTH  signed level written.
- cfg_hold  in  HOLD_W  hold cycles written.
- num_seg  in  $clog2(DEPTH)+1  segments to run (1..DEPTH).
- loop_en  in  1  wrap to segment 0 after last.
- start  in  1  begin sequence (level-sampled).
- stop  in  1  abort sequence.
- v_out_fx  in  WIDTH  model output, fixed-point.
- v_in_fx  out  WIDTH  level driven to model input.
- model_en  out  1  emulator step enable.
- busy  out  1  sequence running.
- seg_idx  out  $clog2(DEPTH)  current segment.
- sample_valid  out  1  one-cycle sample strobe.
- sample_data  out  WIDTH  captured v_out_fx.
- done  out  1  one-cycle completion pulse.

Function
REQ-005 SHALL implement states IDLE, RUN, DONE.
REQ-006 IDLE: start=1, stop=0, 1<=num_seg<=DEPTH -> RUN at next edge; seg_idx=0, v_in_fx=level[0], counter=hold[0].
REQ-007 start with num_seg=0 or num_seg>DEPTH SHALL be ignored (stay IDLE).
REQ-008 num_seg and loop_en SHALL be latched at start; later changes have no effect until next start.
REQ-009 hold value 0 SHALL be treated as 1.
REQ-010 RUN: counter decrements each cycle; busy=1, model_en=1.
REQ-011 On the RUN cycle with counter==1, v_out_fx SHALL be captured into sample_data and sample_valid SHALL be 1 for exactly the following cycle.
REQ-012 Same edge, non-final segment: seg_idx+1, v_in_fx=level[seg_idx+1], counter reload; no gap cycle.
REQ-013 Same edge, final segment (seg_idx==num_seg-1): loop_en latched=1 -> seg_idx=0 and level[0] reload; else -> DONE.
REQ-014 DONE SHALL last one cycle with done=1, busy=0, model_en=0, then IDLE; v_in_fx retains last level.
REQ-015 stop=1 in RUN or DONE -> IDLE at next edge; v_in_fx=0, no sample_valid, no done for the aborted segment.
REQ-016 start and stop both 1 in IDLE: stop SHALL win (stay IDLE).
REQ-017 start while busy SHALL be ignored.
REQ-018 cfg_we SHALL write the table only in IDLE; writes in RUN/DONE ignored.
REQ-019 Table read SHALL be combinational from registered storage; level/hold appear on the same edge seg_idx changes.

Reset
REQ-020 rst=0 SHALL immediately force: state IDLE, v_in_fx=0, model_en=0, busy=0, seg_idx=0, sample_valid=0, sample_data=0, done=0, counter=0.
REQ-021 Reset SHALL clear all table entries to level 0, hold 0.
REQ-022 Reset mid-RUN SHALL abort with no done/sample pulse after release; first start after release behaves per REQ-006.

Structure
REQ-023 Package rc_seq_pkg SHALL hold the state enum, default WIDTH/DEPTH/HOLD_W and the table-entry struct {level, hold}.
REQ-024 Sub-module rc_seq_table SHALL hold the DEPTH-entry register file (one write port, one combinational read port).

Verification
REQ-025 Bench SHALL cover:
- Table {(+0.5,4),(-0.25,2)}, num_seg=2, start -> v_in_fx +0.5 for 4 cycles, -0.25 for 2, sample_valid at cycles 5 and 7, done at cycle 7, busy low at cycle 7.
- Same table, loop_en=1 -> v_in_fx alternates indefinitely, sample_valid every 4 then 2 cycles, no done; stop -> v_in_fx=0 next cycle.
- hold=0 entry -> segment lasts 1 cycle; num_seg=0 start -> stays IDLE.
- start+stop same cycle in IDLE -> busy stays 0; cfg_we during RUN -> table unchanged after done.
- rst=0 asynchronously mid-segment 1 -> all outputs 0 before next clk edge; restart runs segment 0 correctly.
- Constant v_out_fx=0x1F3 -> sample_data=0x1F3 at each sample_valid.
